multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 3, giving the ALUOp width; it SHALL be at least 3, and codes are zero-extended above bit 2.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum wait cycles per memory access before a trap; legal range is 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port opcode, input, 6 bits: instruction[31:26]; it is valid from the DECODE cycle onward.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: memory completion strobe for the current access.
REQ-007 The block SHALL have port trap_clr, input, 1 bit: exits TRAP back to FETCH.
REQ-008 The block SHALL have the following outputs, each 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst.
REQ-009 The block SHALL have outputs PCSource (2 bits), ALUSrcB (2 bits) and ALUOp (ALUOP_W bits).
REQ-010 The block SHALL have output done, 1 bit: one-cycle pulse on the final cycle of each completed instruction.
REQ-011 The block SHALL have output trap, 1 bit: high while in TRAP.
REQ-012 The block SHALL have output state, 4 bits: the current state code, for debug.

Function
REQ-013 The state register SHALL be 4 bits wide, with encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11, TRAP=12.
REQ-014 Codes 13-15 SHALL transition to TRAP on the next edge.
REQ-015 All control outputs SHALL be decoded combinationally from the state register, the latched opcode op_q and mem_ready; any output not listed for a state SHALL be 0.
REQ-016 The ALUOp codes SHALL be: add=000, sub=001, R-type funct=010, and=011, slt=100, or=111.
REQ-017 MemtoReg SHALL select the register-file write source: 0 = memory data, 1 = ALU result.
REQ-018 In FETCH the outputs SHALL be MemRead=1, ALUSrcB=01, ALUOp=add, with IRWrite and PCWrite both equal to mem_ready; the transition to DECODE SHALL occur only when mem_ready=1.
REQ-019 In DECODE the outputs SHALL be ALUSrcB=11 and ALUOp=add, and opcode SHALL be latched into op_q.
REQ-020 The transition out of DECODE SHALL be: 000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000/001100/001101/001010 -> IMMEX; any other opcode -> TRAP.
REQ-021 In MEMADR the outputs SHALL be ALUSrcA=1, ALUSrcB=10, ALUOp=add; the next state SHALL be MEMRD if op_q=100011, otherwise MEMWR.
REQ-022 In MEMRD the outputs SHALL be MemRead=1, IorD=1; the transition to MEMWB SHALL occur when mem_ready=1.
REQ-023 In MEMWB the outputs SHALL be RegWrite=1, MemtoReg=0, RegDst=0, done=1; the next state SHALL be FETCH.
REQ-024 In MEMWR the outputs SHALL be MemWrite=1, IorD=1, and done=mem_ready; the transition to FETCH SHALL occur when mem_ready=1.
REQ-025 In EXEC the outputs SHALL be ALUSrcA=1, ALUSrcB=00, ALUOp=010; the next state SHALL be ALUWB.
REQ-026 In ALUWB the outputs SHALL be RegDst=1, MemtoReg=1, RegWrite=1, done=1; the next state SHALL be FETCH.
REQ-027 In BRANCH the outputs SHALL be ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01, done=1; the next state SHALL be FETCH.
REQ-028 In JUMP the outputs SHALL be PCWrite=1, PCSource=10, done=1; the next state SHALL be FETCH.
REQ-029 In IMMEX the outputs SHALL be ALUSrcA=1, ALUSrcB=10, with ALUOp from op_q: 001000 -> add, 001100 -> and, 001101 -> or, 001010 -> slt; the next state SHALL be IMMWB.
REQ-030 In IMMWB the outputs SHALL be RegDst=0, MemtoReg=1, RegWrite=1, done=1; the next state SHALL be FETCH.
REQ-031 The wait counter SHALL be 8 bits, clear on entry to FETCH, MEMRD or MEMWR, and increment each cycle spent in those states with mem_ready=0.
REQ-032 If the wait counter equals MEM_TIMEOUT with mem_ready=0, the next state SHALL be TRAP, and no write strobe SHALL be issued for that access.
REQ-033 If mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT, mem_ready SHALL take priority and the access SHALL complete normally.
REQ-034 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.
REQ-035 In TRAP, trap SHALL be 1 and all strobes 0; the state SHALL remain TRAP until trap_clr=1, then move to FETCH.
REQ-036 trap_clr SHALL be ignored outside TRAP.
REQ-037 ALUOp bits above bit 2 SHALL be 0 in every state.

Reset
REQ-038 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, set state=FETCH, op_q=0 and the wait counter to 0.
REQ-039 While rst_n=0, every output SHALL be 0 except the FETCH decode (MemRead=1, ALUSrcB=01, ALUOp=000), with IRWrite and PCWrite forced to 0.
REQ-040 Deassertion of rst_n SHALL be synchronised by the integrator; the FSM SHALL start in FETCH on the first edge after release.
REQ-041 Reset asserted mid-instruction SHALL abort the instruction without a done pulse.

Verification
REQ-042 Bench scenario: R-type, opcode=000000, mem_ready=1 in FETCH -> states 0,1,6,7,0; RegWrite=1 and done=1 only in cycle 4; ALUOp=010 in EXEC.
REQ-043 Bench scenario: LW, 100011, with a 3-cycle mem_ready delay in MEMRD -> MEMRD held 3 extra cycles, then MEMWB with MemtoReg=0 and RegWrite=1; SW, 101011 -> MemWrite=1, done pulse in the ready cycle.
REQ-044 Bench scenario: each immediate opcode 001000/001100/001101/001010 -> ALUOp 000/011/111/100 in IMMEX; BEQ -> PCWriteCond=1, PCSource=01; J -> PCWrite=1, PCSource=10.
REQ-045 Bench scenario: illegal opcode 111111 -> TRAP after DECODE, trap=1; hold trap_clr=0 for 5 cycles -> TRAP held; pulse trap_clr -> FETCH.
REQ-046 Bench scenario: MEM_TIMEOUT=4 with mem_ready held low in FETCH -> TRAP after 4 wait cycles with IRWrite never 1; repeat with mem_ready=1 on the 4th cycle -> DECODE.
REQ-047 Bench scenario: rst_n pulsed low in MEMWR while mem_ready=0 -> state=0 asynchronously, MemWrite drops before the next edge, no done pulse.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Control FSM for a multicycle MIPS-style datapath. Sequences
//            fetch / decode / execute / memory / write-back states, generates
//            datapath control strobes and traps on illegal opcodes or memory
//            accesses that exceed MEM_TIMEOUT wait cycles.
// Ports    : clk, rst_n (async, active-low)
//            opcode[5:0]  instruction[31:26], valid from DECODE onward
//            mem_ready    completion strobe for the current memory access
//            trap_clr     leave TRAP and return to FETCH
//            PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
//            IRWrite, ALUSrcA, RegWrite, RegDst, PCSource[1:0],
//            ALUSrcB[1:0], ALUOp[ALUOP_W-1:0]   datapath controls
//            done   one-cycle pulse on the last cycle of an instruction
//            trap   high while in TRAP
//            state  current state code (debug)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  input  logic               trap_clr,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               done,
  output logic               trap,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [2:0] c_aluAdd   = 3'b000;
  localparam logic [2:0] c_aluSub   = 3'b001;
  localparam logic [2:0] c_aluFunct = 3'b010;
  localparam logic [2:0] c_aluAnd   = 3'b011;
  localparam logic [2:0] c_aluSlt   = 3'b100;
  localparam logic [2:0] c_aluOr    = 3'b111;

  localparam logic [5:0] c_opRtype = 6'b000000;
  localparam logic [5:0] c_opLw    = 6'b100011;
  localparam logic [5:0] c_opSw    = 6'b101011;
  localparam logic [5:0] c_opBeq   = 6'b000100;
  localparam logic [5:0] c_opJ     = 6'b000010;
  localparam logic [5:0] c_opAddi  = 6'b001000;
  localparam logic [5:0] c_opAndi  = 6'b001100;
  localparam logic [5:0] c_opOri   = 6'b001101;
  localparam logic [5:0] c_opSlti  = 6'b001010;

  localparam logic [7:0] c_memTimeout = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_nextState;
  logic [5:0] r_opQ;
  logic [7:0] r_waitCnt;
  logic       w_waitState;
  logic       w_timeout;
  logic [2:0] w_aluOp;

  // States that wait on mem_ready and are subject to the timeout.
  assign w_waitState = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  // mem_ready wins over the timeout when both happen in the same cycle.
  assign w_timeout   = (r_waitCnt == c_memTimeout) && !mem_ready;

  // --------------------------------------------------------------------------
  // State, latched opcode and wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_opQ     <= 6'd0;
      r_waitCnt <= 8'd0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_DECODE) begin
        r_opQ <= opcode;
      end
      // Any state change clears the counter, so every entry into a wait
      // state starts counting from zero.
      if (w_nextState != r_state) begin
        r_waitCnt <= 8'd0;
      end else if (w_waitState && !mem_ready) begin
        r_waitCnt <= r_waitCnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_nextState = S_DECODE;
        else if (w_timeout) w_nextState = S_TRAP;
      end
      S_DECODE: begin
        // op_q is not yet loaded here, so decode the live opcode.
        case (opcode)
          c_opRtype:                            w_nextState = S_EXEC;
          c_opLw, c_opSw:                       w_nextState = S_MEMADR;
          c_opBeq:                              w_nextState = S_BRANCH;
          c_opJ:                                w_nextState = S_JUMP;
          c_opAddi, c_opAndi, c_opOri, c_opSlti: w_nextState = S_IMMEX;
          default:                              w_nextState = S_TRAP;
        endcase
      end
      S_MEMADR: w_nextState = (r_opQ == c_opLw) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)      w_nextState = S_MEMWB;
        else if (w_timeout) w_nextState = S_TRAP;
      end
      S_MEMWB: w_nextState = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)      w_nextState = S_FETCH;
        else if (w_timeout) w_nextState = S_TRAP;
      end
      S_EXEC:   w_nextState = S_ALUWB;
      S_ALUWB:  w_nextState = S_FETCH;
      S_BRANCH: w_nextState = S_FETCH;
      S_JUMP:   w_nextState = S_FETCH;
      S_IMMEX:  w_nextState = S_IMMWB;
      S_IMMWB:  w_nextState = S_FETCH;
      S_TRAP: begin
        if (trap_clr) w_nextState = S_FETCH;
      end
      default:  w_nextState = S_TRAP;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    w_aluOp     = c_aluAdd;
    done        = 1'b0;
    trap        = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Gated by rst_n so nothing is written while reset holds FETCH.
        IRWrite = mem_ready & rst_n;
        PCWrite = mem_ready & rst_n;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        done     = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        done     = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        w_aluOp = c_aluFunct;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        done     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        w_aluOp     = c_aluSub;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        done        = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        done     = 1'b1;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (r_opQ)
          c_opAndi: w_aluOp = c_aluAnd;
          c_opOri:  w_aluOp = c_aluOr;
          c_opSlti: w_aluOp = c_aluSlt;
          default:  w_aluOp = c_aluAdd;
        endcase
      end
      S_IMMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        done     = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  // Codes occupy the low three bits; anything wider is zero-extended.
  always_comb begin
    ALUOp      = '0;
    ALUOp[2:0] = w_aluOp;
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed testbench for multicycle_control (ALUOP_W=4 so the
//            zero-extended upper ALUOp bit is observable, MEM_TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       trap_clr;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB;
  logic [3:0] ALUOp;
  logic       done, trap;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .trap_clr(trap_clr), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .done(done),
    .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
  //  RegWrite,RegDst, PCSource, ALUSrcB, ALUOp, done, trap}
  logic [19:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
                ALUOp, done, trap};

  localparam logic [19:0] E_F0    = {10'b0001000000, 2'b00, 2'b01, 4'b0000, 2'b00};
  localparam logic [19:0] E_F1    = {10'b1001001000, 2'b00, 2'b01, 4'b0000, 2'b00};
  localparam logic [19:0] E_DEC   = {10'b0000000000, 2'b00, 2'b11, 4'b0000, 2'b00};
  localparam logic [19:0] E_MADR  = {10'b0000000100, 2'b00, 2'b10, 4'b0000, 2'b00};
  localparam logic [19:0] E_MRD   = {10'b0011000000, 2'b00, 2'b00, 4'b0000, 2'b00};
  localparam logic [19:0] E_MWB   = {10'b0000000010, 2'b00, 2'b00, 4'b0000, 2'b10};
  localparam logic [19:0] E_MWR0  = {10'b0010100000, 2'b00, 2'b00, 4'b0000, 2'b00};
  localparam logic [19:0] E_MWR1  = {10'b0010100000, 2'b00, 2'b00, 4'b0000, 2'b10};
  localparam logic [19:0] E_EXEC  = {10'b0000000100, 2'b00, 2'b00, 4'b0010, 2'b00};
  localparam logic [19:0] E_ALUWB = {10'b0000010011, 2'b00, 2'b00, 4'b0000, 2'b10};
  localparam logic [19:0] E_BR    = {10'b0100000100, 2'b01, 2'b00, 4'b0001, 2'b10};
  localparam logic [19:0] E_JMP   = {10'b1000000000, 2'b10, 2'b00, 4'b0000, 2'b10};
  localparam logic [19:0] E_IMMWB = {10'b0000010010, 2'b00, 2'b00, 4'b0000, 2'b10};
  localparam logic [19:0] E_TRAP  = {18'b0, 2'b01};

  function automatic logic [19:0] immex_exp(input logic [3:0] aluop);
    return {10'b0000000100, 2'b00, 2'b10, aluop, 2'b00};
  endfunction

  // Each task starts one time unit after a rising edge with the DUT in FETCH.
  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; trap_clr = 1'b0;
    #2;
    checks++;
    if (state !== 4'd0 || ctl !== E_F0) begin
      errors++;
      $display("FAIL reset_initial state=%0d ctl=%h expected state=0 ctl=%h", state, ctl, E_F0);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || ctl !== E_F0) begin
      errors++;
      $display("FAIL reset_held state=%0d ctl=%h expected state=0 ctl=%h", state, ctl, E_F0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    int st[$]; logic [19:0] ex[$]; bit mr[$];
    opcode = 6'b000000; trap_clr = 1'b1;   // trap_clr must be ignored here
    st = '{0, 1, 6, 7, 0};
    ex = '{E_F1, E_DEC, E_EXEC, E_ALUWB, E_F0};
    mr = '{1, 1, 1, 1, 0};                 // mem_ready ignored outside waits
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL rtype cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    trap_clr = 1'b0;
  endtask

  task automatic test_lw();
    int st[$]; logic [19:0] ex[$]; bit mr[$];
    opcode = 6'b100011;
    st = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    ex = '{E_F1, E_DEC, E_MADR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB, E_F0};
    mr = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL lw cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    int st[$]; logic [19:0] ex[$]; bit mr[$];
    opcode = 6'b101011;
    st = '{0, 1, 2, 5, 5, 5, 0};
    ex = '{E_F1, E_DEC, E_MADR, E_MWR0, E_MWR0, E_MWR1, E_F0};
    mr = '{1, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL sw cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_immediate();
    logic [5:0] ops [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    logic [3:0] alu [4] = '{4'b0000, 4'b0011, 4'b0111, 4'b0100};
    int st[$]; logic [19:0] ex[$]; bit mr[$];
    st = '{0, 1, 10, 11, 0};
    mr = '{1, 0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      ex = '{E_F1, E_DEC, immex_exp(alu[k]), E_IMMWB, E_F0};
      for (int i = 0; i < st.size(); i++) begin
        mem_ready = mr[i]; #1;
        checks++;
        if (state !== 4'(st[i]) || ctl !== ex[i]) begin
          errors++;
          $display("FAIL imm op=%b cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", ops[k], i, state, ctl, st[i], ex[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch_jump();
    int st[$]; logic [19:0] ex[$]; bit mr[$];
    opcode = 6'b000100;
    st = '{0, 1, 8, 0}; ex = '{E_F1, E_DEC, E_BR, E_F0}; mr = '{1, 1, 1, 0};
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL beq cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    opcode = 6'b000010;
    st = '{0, 1, 9, 0}; ex = '{E_F1, E_DEC, E_JMP, E_F0}; mr = '{1, 0, 0, 0};
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL jump cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    int st[$]; logic [19:0] ex[$]; bit mr[$]; bit tc[$];
    opcode = 6'b111111;
    st = '{0, 1, 12, 12, 12, 12, 12, 12, 0};
    ex = '{E_F1, E_DEC, E_TRAP, E_TRAP, E_TRAP, E_TRAP, E_TRAP, E_TRAP, E_F0};
    mr = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
    tc = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; trap_clr = tc[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    trap_clr = 1'b0;
  endtask

  // MEM_TIMEOUT=4: waiting cycles count 0..4 in FETCH; TRAP follows the cycle
  // at count 4, unless mem_ready arrives in that same cycle.
  task automatic test_fetch_timeout();
    int st[$]; logic [19:0] ex[$]; bit mr[$]; bit tc[$];
    opcode = 6'b000010;
    st = '{0, 1, 9, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 1, 9, 0};
    ex = '{E_F1, E_DEC, E_JMP, E_F0, E_F0, E_F0, E_F0, E_F0, E_TRAP,
           E_F0, E_F0, E_F0, E_F0, E_F1, E_DEC, E_JMP, E_F0};
    mr = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tc = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; trap_clr = tc[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL fetch_timeout cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    trap_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    int st[$]; logic [19:0] ex[$]; bit mr[$];
    opcode = 6'b101011;
    st = '{0, 1, 2, 5}; ex = '{E_F1, E_DEC, E_MADR, E_MWR0}; mr = '{1, 0, 0, 0};
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL areset_pre cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    // Still in MEMWR waiting; drop reset between edges.
    #1;
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL areset_memwr state=%0d MemWrite=%b expected state=5 MemWrite=1", state, MemWrite);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (state !== 4'd0 || MemWrite !== 1'b0 || done !== 1'b0 || ctl !== E_F0) begin
      errors++;
      $display("FAIL areset_async state=%0d MemWrite=%b done=%b ctl=%h expected state=0 MemWrite=0 done=0 ctl=%h", state, MemWrite, done, ctl, E_F0);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || ctl !== E_F0) begin
      errors++;
      $display("FAIL areset_hold state=%0d ctl=%h expected state=0 ctl=%h", state, ctl, E_F0);
    end
    rst_n = 1'b1;
    st = '{0, 1, 2, 5, 0}; ex = '{E_F1, E_DEC, E_MADR, E_MWR1, E_F0}; mr = '{1, 0, 0, 1, 0};
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (state !== 4'(st[i]) || ctl !== ex[i]) begin
        errors++;
        $display("FAIL areset_post cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h", i, state, ctl, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_immediate();
    test_branch_jump();
    test_illegal();
    test_fetch_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
